// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the memory arbiter: FSM encoding, owner ids, default latency
// and the round-robin pick helper.
package mem_arbiter_pkg;

   localparam logic [1:0] ST_IDLE   = 2'b00;
   localparam logic [1:0] ST_ACCESS = 2'b01;
   localparam logic [1:0] ST_DONE   = 2'b10;

   localparam logic OWN_CPU    = 1'b0;
   localparam logic OWN_LOADER = 1'b1;

   localparam int MEM_LAT_DEF = 2;

   // Round-robin choice between two requesters; on contention the one that did not go last wins.
   function automatic logic rr_pick(input logic r0, input logic r1, input logic last_owner);
      logic win;
      if (r0 && r1) begin
         win = ~last_owner;
      end else if (r1) begin
         win = OWN_LOADER;
      end else begin
         win = OWN_CPU;
      end
      return win;
   endfunction

endpackage

// File: rtl/mem_arbiter_latency_counter.sv
// Loadable down-counter that times the memory access window; zero marks the final
// ACCESS cycle.
module arb_latency_counter #(
   parameter int CNT_W = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] count_r;

   // Count register: load wins over decrement, and the count never wraps below zero.
   always_ff @(posedge clock) begin
      if (reset) begin
         count_r <= {CNT_W{1'b0}};
      end else if (load) begin
         count_r <= load_val;
      end else if (dec && (count_r != {CNT_W{1'b0}})) begin
         count_r <= count_r - CNT_W'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign zero = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter for the shared unified memory: CPU control path
// (requester 0) and boot/IO loader (requester 1).
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int MEM_LAT = MEM_LAT_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              ack0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              grant,
   output logic              busy
);

   localparam int CNT_W = $clog2(MEM_LAT) + 1;
   localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

   logic [1:0]        state_r;
   logic [1:0]        next_state_s;
   logic              last_owner_r;
   logic              grant_r;
   logic              busy_r;
   logic              ack0_r;
   logic              ack1_r;
   logic              mem_we_r;
   logic [ADDR_W-1:0] mem_addr_r;
   logic [DATA_W-1:0] mem_wdata_r;
   logic [DATA_W-1:0] rdata_r;

   logic              any_req_s;
   logic              winner_s;
   logic              cnt_load_s;
   logic              cnt_dec_s;
   logic              cnt_zero_s;

   assign any_req_s = req0 | req1;
   assign winner_s  = rr_pick(req0, req1, last_owner_r);

   arb_latency_counter #(
      .CNT_W (CNT_W)
   ) u_lat_cnt (
      .clock    (clock),
      .reset    (reset),
      .load     (cnt_load_s),
      .load_val (LAT_LOAD),
      .dec      (cnt_dec_s),
      .zero     (cnt_zero_s)
   );

   // Next-state and counter control.
   always_comb begin
      next_state_s = state_r;
      cnt_load_s   = 1'b0;
      cnt_dec_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (any_req_s) begin
               next_state_s = ST_ACCESS;
               cnt_load_s   = 1'b1;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            if (cnt_zero_s) begin
               next_state_s = ST_DONE;
            end else begin
               cnt_dec_s    = 1'b1;
            end
         end
         ST_DONE: begin
            next_state_s = ST_IDLE;
         end
         default: begin
            next_state_s = ST_IDLE;
         end
      endcase
   end

   // State, round-robin pointer and all registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         last_owner_r <= OWN_LOADER;
         grant_r      <= OWN_CPU;
         busy_r       <= 1'b0;
         ack0_r       <= 1'b0;
         ack1_r       <= 1'b0;
         mem_we_r     <= 1'b0;
         mem_addr_r   <= {ADDR_W{1'b0}};
         mem_wdata_r  <= {DATA_W{1'b0}};
         rdata_r      <= {DATA_W{1'b0}};
      end else begin
         state_r <= next_state_s;
         busy_r  <= (next_state_s != ST_IDLE);
         ack0_r  <= 1'b0;
         ack1_r  <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (any_req_s) begin
                  grant_r      <= winner_s;
                  last_owner_r <= winner_s;
                  mem_we_r     <= (winner_s == OWN_LOADER) ? we1    : we0;
                  mem_addr_r   <= (winner_s == OWN_LOADER) ? addr1  : addr0;
                  mem_wdata_r  <= (winner_s == OWN_LOADER) ? wdata1 : wdata0;
               end else begin
                  mem_we_r     <= 1'b0;
               end
            end
            ST_ACCESS: begin
               if (cnt_zero_s) begin
                  // mem_we_r still carries the latched op here, so it tells read from write.
                  if (!mem_we_r) begin
                     rdata_r <= mem_rdata;
                  end else begin
                     rdata_r <= rdata_r;
                  end
                  mem_we_r <= 1'b0;
                  ack0_r   <= (grant_r == OWN_CPU);
                  ack1_r   <= (grant_r == OWN_LOADER);
               end else begin
                  mem_we_r <= mem_we_r;
               end
            end
            ST_DONE: begin
               mem_we_r <= 1'b0;
            end
            default: begin
               mem_we_r <= 1'b0;
            end
         endcase
      end
   end

   assign ack0      = ack0_r;
   assign ack1      = ack1_r;
   assign rdata     = rdata_r;
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;
   assign mem_we    = mem_we_r;
   assign grant     = grant_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small behavioural memory; expected values are
// hand-computed for MEM_LAT=2.
module tb_mem_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        req0, we0, req1, we1;
   logic [15:0] addr0, wdata0, addr1, wdata1;
   logic        ack0, ack1, mem_we, grant, busy;
   logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
   logic        mem_init;
   logic [15:0] mem [0:255];

   int checks_cnt = 0;
   int fail_cnt   = 0;
   int we_cnt, ack_cyc, n_acks, lat;
   logic [3:0] owners;
   int         ack_at [0:3];

   always #5 clock = ~clock;

   mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(2)) dut (
      .clock(clock), .reset(reset),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
      .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_rdata(mem_rdata), .grant(grant), .busy(busy)
   );

   assign mem_rdata = mem[mem_addr[7:0]];

   always @(posedge clock) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
         mem[8'h10] <= 16'hBEEF;
         mem[8'h20] <= 16'hCAFE;
      end else if (mem_we) begin
         mem[mem_addr[7:0]] <= mem_wdata;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_cnt++;
      if (got !== exp) begin
         fail_cnt++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   initial begin
      reset = 1'b1; mem_init = 1'b1;
      req0 = 1'b0; we0 = 1'b0; addr0 = 16'h0000; wdata0 = 16'h0000;
      req1 = 1'b0; we1 = 1'b0; addr1 = 16'h0000; wdata1 = 16'h0000;
      repeat (3) @(negedge clock);
      reset = 1'b0; mem_init = 1'b0;

      // reset then idle
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         chk("idle_ctl", {27'd0, ack0, ack1, mem_we, grant, busy}, 32'd0);
      end
      chk("idle_addr", {16'd0, mem_addr}, 32'h0000);
      chk("idle_wdata", {16'd0, mem_wdata}, 32'h0000);
      chk("idle_rdata", {16'd0, rdata}, 32'h0000);

      // single CPU read of 0x0010
      req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010;
      @(negedge clock);
      chk("rd_c1_addr", {16'd0, mem_addr}, 32'h0010);
      chk("rd_c1_ctl", {28'd0, busy, grant, mem_we, ack0}, {28'd0, 4'b1000});
      @(negedge clock);
      chk("rd_c2_addr", {16'd0, mem_addr}, 32'h0010);
      chk("rd_c2_ack", {31'd0, ack0}, 32'd0);
      @(negedge clock);
      chk("rd_c3_ack0", {31'd0, ack0}, 32'd1);
      chk("rd_c3_ack1", {31'd0, ack1}, 32'd0);
      chk("rd_c3_rdata", {16'd0, rdata}, 32'hBEEF);
      req0 = 1'b0;
      @(negedge clock);
      chk("rd_c4_ctl", {29'd0, ack0, ack1, busy}, 32'd0);

      // loader write of 0x1234 to 0x0004
      req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0004; wdata1 = 16'h1234;
      we_cnt = 0; ack_cyc = 0;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clock);
         if (mem_we) we_cnt++;
         if (ack1) begin
            ack_cyc = c;
            req1 = 1'b0;
         end
         chk("wr_no_ack0", {31'd0, ack0}, 32'd0);
      end
      chk("wr_we_cycles", we_cnt, 32'd2);
      chk("wr_ack_cycle", ack_cyc, 32'd3);
      chk("wr_mem", {16'd0, mem[8'h04]}, 32'h1234);
      chk("wr_rdata_hold", {16'd0, rdata}, 32'hBEEF);
      chk("wr_grant", {31'd0, grant}, 32'd1);

      // saturated requests straight after reset
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010;
      req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0020;
      n_acks = 0; owners = 4'b0000;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clock);
         chk("sat_no_overlap", {31'd0, ack0 & ack1}, 32'd0);
         if ((ack0 | ack1) && n_acks < 4) begin
            owners[n_acks] = ack1;
            ack_at[n_acks] = c;
            n_acks++;
         end
      end
      req0 = 1'b0; req1 = 1'b0;
      chk("sat_n_acks", n_acks, 32'd4);
      chk("sat_owners", {28'd0, owners}, {28'd0, 4'b1010});
      for (int k = 0; k < 4; k++) chk("sat_ack_cycle", ack_at[k], 3 + 4 * k);
      repeat (2) @(negedge clock);
      chk("sat_idle", {31'd0, busy}, 32'd0);

      // address change during ACCESS is ignored
      req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010;
      @(negedge clock);
      addr0 = 16'h0020;
      chk("hold_c1", {16'd0, mem_addr}, 32'h0010);
      @(negedge clock);
      chk("hold_c2", {16'd0, mem_addr}, 32'h0010);
      @(negedge clock);
      chk("hold_c3", {16'd0, mem_addr}, 32'h0010);
      chk("hold_ack", {31'd0, ack0}, 32'd1);
      chk("hold_rdata", {16'd0, rdata}, 32'hBEEF);
      req0 = 1'b0;
      @(negedge clock);
      chk("hold_c4", {16'd0, mem_addr}, 32'h0010);

      // reset in the second ACCESS cycle of a write
      req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0030; wdata0 = 16'h5555;
      @(negedge clock);
      chk("rst_we_c1", {31'd0, mem_we}, 32'd1);
      @(negedge clock);
      chk("rst_we_c2", {31'd0, mem_we}, 32'd1);
      reset = 1'b1; req0 = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      chk("rst_ctl", {27'd0, ack0, ack1, mem_we, grant, busy}, 32'd0);
      chk("rst_addr", {16'd0, mem_addr}, 32'h0000);
      chk("rst_rdata", {16'd0, rdata}, 32'h0000);
      @(negedge clock);
      chk("rst_no_ack", {30'd0, ack0, ack1}, 32'd0);
      req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010;
      lat = 0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clock);
         if (ack0 && lat == 0) begin
            lat = c;
            req0 = 1'b0;
         end
      end
      chk("post_rst_latency", lat, 32'd3);
      chk("post_rst_rdata", {16'd0, rdata}, 32'hBEEF);

      $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the processor's single-port unified memory between the multicycle CPU control path (requester 0) and the boot/IO loader (requester 1). It grants one access at a time with round-robin fairness and holds the memory address, data and write enable stable for a fixed memory latency. It returns read data with a one-cycle acknowledge. It sits between the datapath's memory-address/IorD mux and the memory array.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- MEM_LAT, 2, cycles the memory needs per access (≥1)

- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- req0  in  1  CPU access request; held high until ack0
- we0  in  1  CPU write (1) / read (0); valid while req0
- addr0  in  ADDR_W  CPU address
- wdata0  in  DATA_W  CPU write data
- ack0  out  1  one-cycle completion pulse to CPU
- req1, we1, addr1, wdata1  in  (same widths)  loader request bundle
- ack1  out  1  one-cycle completion pulse to loader
- rdata  out  DATA_W  read data of the last completed read; held until the next read completes
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_we  out  1  memory write strobe
- mem_rdata  in  DATA_W  memory read data
- grant  out  1  current or last owner (0 = CPU, 1 = loader)
- busy  out  1  high whenever state ≠ IDLE

## Operation
- Reset values: ack0=ack1=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, grant=0, busy=0, last_owner=1, state=IDLE, counter=0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant that requester.
  - Both requesting: grant the requester ≠ last_owner. After reset this grants the CPU first.
  - On grant: latch we/addr/wdata of the winner into mem_we/mem_addr/mem_wdata, set grant and last_owner, load counter=MEM_LAT-1, go to ACCESS.
- ACCESS: mem outputs are held constant. mem_we=latched we for every ACCESS cycle.
  - Counter>0: decrement.
  - Counter==0: if read, capture mem_rdata into rdata; drive mem_we=0; go to DONE.
- DONE: assert ack of the granted requester for exactly one cycle, then go to IDLE. mem_addr holds its value; mem_we=0.
- Requester rule: req must drop on the edge where ack is sampled high. A req still high in the following IDLE cycle is treated as a new access.
- Inputs of the non-granted requester are ignored until the next IDLE arbitration. A req edge during ACCESS/DONE is not lost; it waits.
- Requester inputs changing during ACCESS have no effect because they are latched at grant.
- Reset mid-operation: the next cycle is IDLE with all outputs at reset values, and no ack is issued. Reset during a write truncates the strobe; the memory contents at that address are undefined.

## Timing
- Grant decision in the IDLE cycle where req is sampled (cycle 0). ACCESS occupies cycles 1..MEM_LAT. ack is high in cycle MEM_LAT+1.
- Request-to-ack latency is MEM_LAT+1 cycles. Back-to-back throughput is one access per MEM_LAT+2 cycles.
- With both requesters saturated, grants alternate 0,1,0,1…
- rdata is valid from the ack cycle onward.
- mem_we is never high in IDLE or DONE.

## Structure
- Shared package holds:
  - state encoding IDLE=2'b00, ACCESS=2'b01, DONE=2'b10
  - owner constants OWN_CPU=0, OWN_LOADER=1
  - default MEM_LAT
- One sub-module, arb_latency_counter: loadable down-counter with a zero flag, width $clog2(MEM_LAT)+1.
- FSM, round-robin pointer and output registers stay in mem_arbiter.

## Test plan
- Reset then idle: 5 cycles with no req -> all outputs 0, busy=0.
- Single CPU read: req0=1, we0=0, addr0=0x0010, memory[0x0010]=0xBEEF, MEM_LAT=2 -> mem_addr=0x0010 in cycles 1–2, ack0 in cycle 3, rdata=0xBEEF, ack1 never high.
- Loader write: req1=1, we1=1, addr1=0x0004, wdata1=0x1234 -> mem_we=1 for exactly 2 cycles, ack1 in cycle 3, memory[0x0004]=0x1234, rdata unchanged.
- Simultaneous saturated requests from reset -> grant sequence 0,1,0,1. Each ack is 4 cycles apart. No ack0/ack1 overlap.
- addr0 changed mid-ACCESS from 0x0010 to 0x0020 -> mem_addr stays 0x0010 through DONE.
- reset asserted in the second ACCESS cycle of a write -> next cycle IDLE, mem_we=0, no ack. A subsequent req0 read completes normally with 3-cycle latency.
